// File: rtl/dkong3_snd_pkg.sv
// rtl/dkong3_snd_pkg.sv - shared types and widths for the sound-CPU command mailbox
package dkong3_snd_pkg;
   typedef enum logic {NMI_IDLE, NMI_PULSE} nmi_state_t;
   localparam int CMD_W = 8;
   localparam int OVR_W = 4;
   localparam int CNT_W = 8;
endpackage

// File: rtl/dkong3_mbox_chan.sv
// rtl/dkong3_mbox_chan.sv - one mailbox channel: command latch, pending flag, overrun count, NMI pulse
module dkong3_mbox_chan
   import dkong3_snd_pkg::*;
#(
   parameter int NMI_W   = 32,
   parameter int OVR_MAX = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sub_resetn,
   input  logic             wr_stb_n,
   input  logic [CMD_W-1:0] db,
   input  logic             sub_rd_n,
   input  logic             vblk_fall,
   output logic [CMD_W-1:0] latch,
   output logic             pend,
   output logic [OVR_W-1:0] ovr_cnt,
   output logic             nmi_n
);
   logic [CMD_W-1:0] shadow;
   logic             stb_prev;
   logic             rd_prev;
   logic             capture;
   logic             rd_clr;
   nmi_state_t       state, next_state;
   logic [CNT_W-1:0] cnt, next_cnt;

   assign capture = ~stb_prev & wr_stb_n;
   assign rd_clr  = rd_prev & ~sub_rd_n;

   // History regs reset high so releasing reset with lines idle yields no edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow   <= '0;
         latch    <= '0;
         pend     <= 1'b0;
         ovr_cnt  <= '0;
         stb_prev <= 1'b1;
         rd_prev  <= 1'b1;
      end else begin
         stb_prev <= wr_stb_n;
         rd_prev  <= sub_rd_n;
         if (!wr_stb_n)
            shadow <= db;
         if (capture)
            latch <= shadow;
         // A read landing with the capture means the old command was consumed
         if (capture && pend && !rd_clr && ovr_cnt != OVR_W'(OVR_MAX))
            ovr_cnt <= ovr_cnt + 1'b1;
         if (!sub_resetn)
            pend <= 1'b0;
         else if (capture)
            pend <= 1'b1;
         else if (rd_clr)
            pend <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= NMI_IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      nmi_n      = 1'b1;
      case (state)
         NMI_IDLE: begin
            if (vblk_fall && sub_resetn) begin
               next_state = NMI_PULSE;
               next_cnt   = CNT_W'(NMI_W - 1);
            end
         end
         NMI_PULSE: begin
            nmi_n = 1'b0;
            if (cnt == '0)
               next_state = NMI_IDLE;
            else
               next_cnt = cnt - CNT_W'(1);
         end
         default: next_state = NMI_IDLE;
      endcase
      if (!sub_resetn) begin
         next_state = NMI_IDLE;
         next_cnt   = '0;
      end
   end
endmodule

// File: rtl/dkong3_snd_mailbox.sv
// rtl/dkong3_snd_mailbox.sv - main-to-sound CPU command mailbox with per-channel VBLANK NMI
module dkong3_snd_mailbox
   import dkong3_snd_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int NMI_W   = 32,
   parameter int OVR_MAX = 15
) (
   input  logic                    I_CLK,
   input  logic                    I_RESET_n,
   input  logic                    I_SUB_RESETn,
   input  logic [NUM_CH-1:0]       I_WR_STB_n,
   input  logic [CMD_W-1:0]        I_DB,
   input  logic [NUM_CH-1:0]       I_SUB_RD_n,
   input  logic                    I_VBLK_n,
   output logic [CMD_W*NUM_CH-1:0] O_LATCH,
   output logic [NUM_CH-1:0]       O_PEND,
   output logic [OVR_W*NUM_CH-1:0] O_OVR_CNT,
   output logic [NUM_CH-1:0]       O_SUB_NMI_n
);
   logic vblk_prev;
   logic vblk_fall;

   // One VBLANK edge detector shared so every sub CPU sees the same frame tick
   always_ff @(posedge I_CLK or negedge I_RESET_n) begin
      if (!I_RESET_n)
         vblk_prev <= 1'b1;
      else
         vblk_prev <= I_VBLK_n;
   end

   assign vblk_fall = vblk_prev & ~I_VBLK_n;

   for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
      dkong3_mbox_chan #(
         .NMI_W   (NMI_W),
         .OVR_MAX (OVR_MAX)
      ) u_chan (
         .clk        (I_CLK),
         .rst_n      (I_RESET_n),
         .sub_resetn (I_SUB_RESETn),
         .wr_stb_n   (I_WR_STB_n[n]),
         .db         (I_DB),
         .sub_rd_n   (I_SUB_RD_n[n]),
         .vblk_fall  (vblk_fall),
         .latch      (O_LATCH[CMD_W*n +: CMD_W]),
         .pend       (O_PEND[n]),
         .ovr_cnt    (O_OVR_CNT[OVR_W*n +: OVR_W]),
         .nmi_n      (O_SUB_NMI_n[n])
      );
   end
endmodule

// File: tb/tb_dkong3_snd_mailbox.sv
// tb/tb_dkong3_snd_mailbox.sv - directed bench with rule-level reference model for the mailbox
module tb_dkong3_snd_mailbox;
   localparam int NCH = 2;
   localparam int NW  = 32;
   localparam int OMX = 15;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             sub_resetn;
   logic [NCH-1:0]   stb_n;
   logic [7:0]       db;
   logic [NCH-1:0]   rd_n;
   logic             vblk_n;
   logic [8*NCH-1:0] o_latch;
   logic [NCH-1:0]   o_pend;
   logic [4*NCH-1:0] o_ovr;
   logic [NCH-1:0]   o_nmi_n;

   int n_checks = 0;
   int n_errors = 0;

   dkong3_snd_mailbox #(.NUM_CH(NCH), .NMI_W(NW), .OVR_MAX(OMX)) dut (
      .I_CLK        (clk),
      .I_RESET_n    (rst_n),
      .I_SUB_RESETn (sub_resetn),
      .I_WR_STB_n   (stb_n),
      .I_DB         (db),
      .I_SUB_RD_n   (rd_n),
      .I_VBLK_n     (vblk_n),
      .O_LATCH      (o_latch),
      .O_PEND       (o_pend),
      .O_OVR_CNT    (o_ovr),
      .O_SUB_NMI_n  (o_nmi_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: command mailbox rules, NMI tracked as remaining low cycles
   int   m_latch [NCH];
   int   m_shadow[NCH];
   int   m_pend  [NCH];
   int   m_ovr   [NCH];
   int   m_left  [NCH];
   logic m_pstb  [NCH];
   logic m_prd   [NCH];
   logic m_pvblk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_latch[c] = 0; m_shadow[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
            m_left[c] = 0; m_pstb[c] = 1'b1; m_prd[c] = 1'b1;
         end
         m_pvblk = 1'b1;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            bit cap, rdc;
            cap = !m_pstb[c] && stb_n[c];
            rdc = m_prd[c] && !rd_n[c];
            if (cap) begin
               m_latch[c] = m_shadow[c];
               if (m_pend[c] == 1 && !rdc && m_ovr[c] < OMX) m_ovr[c] = m_ovr[c] + 1;
            end
            if (!sub_resetn) m_pend[c] = 0;
            else if (cap) m_pend[c] = 1;
            else if (rdc) m_pend[c] = 0;
            if (!stb_n[c]) m_shadow[c] = db;
            if (!sub_resetn) m_left[c] = 0;
            else if (m_left[c] > 0) m_left[c] = m_left[c] - 1;
            else if (m_pvblk && !vblk_n) m_left[c] = NW;
            m_pstb[c] = stb_n[c];
            m_prd[c]  = rd_n[c];
         end
         m_pvblk = vblk_n;
      end
   end

   always @(negedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("model latch ch%0d", c), 32'(o_latch[8*c +: 8]), 32'(m_latch[c]));
         chk($sformatf("model pend ch%0d", c), 32'(o_pend[c]), 32'(m_pend[c]));
         chk($sformatf("model ovr ch%0d", c), 32'(o_ovr[4*c +: 4]), 32'(m_ovr[c]));
         chk($sformatf("model nmi_n ch%0d", c), 32'(o_nmi_n[c]), 32'(m_left[c] == 0));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   int low0, low1;

   initial begin
      rst_n = 1'b1; sub_resetn = 1'b1; stb_n = '1; db = 8'h00; rd_n = '1; vblk_n = 1'b1;
      #1 rst_n = 1'b0;
      step(2);
      chk("reset latch", 32'(o_latch), 32'h0);
      chk("reset pend", 32'(o_pend), 32'h0);
      chk("reset ovr", 32'(o_ovr), 32'h0);
      chk("reset nmi_n", 32'(o_nmi_n), 32'h3);
      rst_n = 1'b1;
      step(2);

      // 1: capture on ch0
      stb_n[0] = 1'b0; db = 8'h5A;
      step(4);
      chk("t1 pend before rise", 32'(o_pend[0]), 32'h0);
      stb_n[0] = 1'b1; db = 8'hFF;
      step(1);
      chk("t1 latch0", 32'(o_latch[7:0]), 32'h5A);
      chk("t1 pend0", 32'(o_pend[0]), 32'h1);
      chk("t1 latch1 untouched", 32'(o_latch[15:8]), 32'h0);
      chk("t1 pend1 untouched", 32'(o_pend[1]), 32'h0);

      // 2: overrun on ch1
      stb_n[1] = 1'b0; db = 8'h11; step(2); stb_n[1] = 1'b1; step(1);
      stb_n[1] = 1'b0; db = 8'h22; step(2); stb_n[1] = 1'b1; step(1);
      chk("t2 latch1", 32'(o_latch[15:8]), 32'h22);
      chk("t2 ovr1 one", 32'(o_ovr[7:4]), 32'h1);
      for (int i = 0; i < 20; i++) begin
         stb_n[1] = 1'b0; db = 8'(i); step(1); stb_n[1] = 1'b1; step(1);
      end
      chk("t2 ovr1 saturated", 32'(o_ovr[7:4]), 32'hF);
      chk("t2 latch1 last", 32'(o_latch[15:8]), 32'h13);

      // 3: read-clear colliding with capture, then read alone
      stb_n[0] = 1'b0; db = 8'h33; step(2);
      stb_n[0] = 1'b1; rd_n[0] = 1'b0; step(1);
      chk("t3 pend0 capture wins", 32'(o_pend[0]), 32'h1);
      chk("t3 ovr0 unchanged", 32'(o_ovr[3:0]), 32'h0);
      chk("t3 latch0", 32'(o_latch[7:0]), 32'h33);
      rd_n[0] = 1'b1; step(2);
      rd_n[0] = 1'b0; step(1);
      chk("t3 pend0 cleared", 32'(o_pend[0]), 32'h0);
      chk("t3 latch0 kept", 32'(o_latch[7:0]), 32'h33);
      rd_n[0] = 1'b1; step(2);

      // 4: NMI width with a retrigger attempt mid-pulse
      vblk_n = 1'b0; step(1);
      low0 = (o_nmi_n[0] == 1'b0) ? 1 : 0;
      low1 = (o_nmi_n[1] == 1'b0) ? 1 : 0;
      for (int i = 1; i < 60; i++) begin
         if (i == 8) vblk_n = 1'b1;
         if (i == 9) vblk_n = 1'b0;
         step(1);
         if (o_nmi_n[0] == 1'b0) low0++;
         if (o_nmi_n[1] == 1'b0) low1++;
      end
      chk("t4 nmi0 low cycles", 32'(low0), 32'd32);
      chk("t4 nmi1 low cycles", 32'(low1), 32'd32);
      vblk_n = 1'b1; step(2);

      // 5: sub reset during pulse with ch1 pending
      vblk_n = 1'b0; step(1); step(5);
      chk("t5 nmi low before sub reset", 32'(o_nmi_n), 32'h0);
      sub_resetn = 1'b0; step(1);
      chk("t5 nmi released", 32'(o_nmi_n), 32'h3);
      chk("t5 pend1 cleared", 32'(o_pend[1]), 32'h0);
      chk("t5 latch1 kept", 32'(o_latch[15:8]), 32'h13);
      chk("t5 ovr1 kept", 32'(o_ovr[7:4]), 32'hF);
      vblk_n = 1'b1; step(1); vblk_n = 1'b0; step(3);
      chk("t5 no nmi while held", 32'(o_nmi_n), 32'h3);
      stb_n[0] = 1'b0; db = 8'h44; step(1); stb_n[0] = 1'b1; step(1);
      chk("t5 capture in sub reset", 32'(o_latch[7:0]), 32'h44);
      chk("t5 pend held low", 32'(o_pend[0]), 32'h0);
      sub_resetn = 1'b1; vblk_n = 1'b1; step(2);

      // 6: async reset mid-strobe and mid-pulse
      vblk_n = 1'b0; step(3);
      stb_n[0] = 1'b0; db = 8'h77; step(2);
      #1 rst_n = 1'b0;
      #1;
      chk("t6 latch reset", 32'(o_latch), 32'h0);
      chk("t6 pend reset", 32'(o_pend), 32'h0);
      chk("t6 ovr reset", 32'(o_ovr), 32'h0);
      chk("t6 nmi reset", 32'(o_nmi_n), 32'h3);
      stb_n[0] = 1'b1; vblk_n = 1'b1;
      step(2);
      rst_n = 1'b1;
      step(3);
      chk("t6 no spurious latch", 32'(o_latch), 32'h0);
      chk("t6 no spurious pend", 32'(o_pend), 32'h0);
      stb_n[0] = 1'b0; db = 8'hA5; step(1); stb_n[0] = 1'b1; db = 8'h00; step(1);
      chk("t6 capture after reset", 32'(o_latch[7:0]), 32'hA5);
      chk("t6 pend after reset", 32'(o_pend[0]), 32'h1);
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
